// File: rtl/m_dram_resp.sv
// m_dram_resp: single-port data memory behind a fixed-latency request FSM.
// A load or store strobe in IDLE is latched and then occupies LATENCY busy
// cycles. The memory write (stores) or result update (loads) happens on the
// final busy cycle. Misaligned or illegal-size requests still take the full
// window, have no side effect and raise a one-cycle error pulse.
//
// Handshake: a request is taken on any posedge where the block is IDLE
// (dbg_state_o == 0, w_dram_busy == 0), RST_X is high and w_dram_le or
// w_dram_we_t is high. Strobes seen while busy are dropped, not queued. The
// request is complete on the edge where w_dram_busy falls. On that same
// edge w_dram_odata (valid loads) or w_dram_err (bad requests) updates.
module m_dram_resp #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input  logic        CLK,
  input  logic        RST_X,
  input  logic [31:0] w_dram_addr,
  input  logic [31:0] w_dram_wdata,
  input  logic        w_dram_we_t,
  input  logic        w_dram_le,
  input  logic [2:0]  w_dram_ctrl,
  output logic [31:0] w_dram_odata,
  output logic        w_dram_busy,
  output logic        w_dram_err,
  output logic        dbg_state_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // The counter is loaded with LATENCY-1 at acceptance.
  // The access finishes on the edge where the counter is already zero.
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic [31:0] odata_q, odata_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        store_q, store_d;

  logic        accept;
  logic        last_cycle;
  logic        illegal_ctrl;
  logic        misaligned;
  logic        bad_req;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_value;
  logic [3:0]  wr_be;
  logic [31:0] wr_lanes;
  logic        mem_we;

  // Upper address bits alias onto the same words.
  // Only the index slice is used.
  logic [31:0] unused_addr;
  assign unused_addr = addr_q;

  logic [31:0] mem [0:DEPTH-1];

  assign accept     = (state_q == S_IDLE) && (w_dram_le || w_dram_we_t);
  assign last_cycle = (state_q == S_ACCESS) && (cnt_q == 4'd0);
  assign idx        = addr_q[ADDR_WIDTH+1:2];

  assign w_dram_odata = odata_q;
  assign w_dram_busy  = busy_q;
  assign w_dram_err   = err_q;
  assign dbg_state_o  = state_q;

  // Request classification on the latched size code and address.
  always_comb begin
    illegal_ctrl = 1'b0;
    misaligned   = 1'b0;
    case (ctrl_q)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = addr_q[0];
      3'b010:         misaligned = (addr_q[1:0] != 2'b00);
      default:        illegal_ctrl = 1'b1;
    endcase
    bad_req = illegal_ctrl || misaligned;
  end

  // Load path: pick the addressed lane and extend it per the size code.
  always_comb begin
    rd_word  = mem[idx];
    rd_byte  = rd_word[{addr_q[1:0], 3'b000} +: 8];
    rd_half  = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    ld_value = rd_word;
    case (ctrl_q)
      3'b000:  ld_value = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  ld_value = {24'd0, rd_byte};
      3'b001:  ld_value = {{16{rd_half[15]}}, rd_half};
      3'b101:  ld_value = {16'd0, rd_half};
      default: ld_value = rd_word;
    endcase
  end

  // Store path: replicate the right-aligned data onto every lane.
  // The byte enables then select the lanes that are written.
  always_comb begin
    wr_be    = 4'b1111;
    wr_lanes = wdata_q;
    case (ctrl_q[1:0])
      2'b00: begin
        wr_be    = 4'b0001 << addr_q[1:0];
        wr_lanes = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        wr_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{wdata_q[15:0]}};
      end
      default: begin
        wr_be    = 4'b1111;
        wr_lanes = wdata_q;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: IDLE -> ACCESS on a strobe, back to IDLE when the counter expires.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_ACCESS;
      S_ACCESS: if (cnt_q == 4'd0) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs: latch on accept, count down, complete on the final cycle.
  always_comb begin
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    err_d   = 1'b0;
    odata_d = odata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ctrl_d  = ctrl_q;
    store_d = store_q;
    mem_we  = 1'b0;
    if (accept) begin
      addr_d  = w_dram_addr;
      wdata_d = w_dram_wdata;
      ctrl_d  = w_dram_ctrl;
      // A combined load+store strobe is treated as a store.
      store_d = w_dram_we_t;
      cnt_d   = LAT_M1;
      busy_d  = 1'b1;
    end else if (state_q == S_ACCESS) begin
      if (last_cycle) begin
        busy_d = 1'b0;
        err_d  = bad_req;
        mem_we = store_q && !bad_req;
        if (!store_q && !bad_req) begin
          odata_d = ld_value;
        end
      end else begin
        cnt_d = 4'(cnt_q - 4'd1);
      end
    end
  end

  // Control and datapath registers.
  // Reset aborts any in-flight access and clears the outputs.
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      odata_q <= 32'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      ctrl_q  <= 3'd0;
      store_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      odata_q <= odata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ctrl_q  <= ctrl_d;
      store_q <= store_d;
    end
  end

  // Byte-enabled memory write on a store's final cycle.
  // The array is never reset or initialised.
  always_ff @(posedge CLK) begin
    if (mem_we && RST_X) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) begin
          mem[idx][8*i +: 8] <= wr_lanes[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_m_dram_resp.sv
// Testbench for m_dram_resp.
// Two instances are driven: LATENCY=2 (main) and LATENCY=1 (short-latency case).
// A reference memory model produces the expected {err, odata} for each request.
module tb_m_dram_resp;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- stimulus / DUT signals ----------------
  logic        sel;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_we;
  logic        w_le;
  logic [2:0]  w_ctrl;

  logic [31:0] od0, od1;
  logic        busy0, busy1, err0, err1, st0, st1;

  m_dram_resp #(.ADDR_WIDTH(12), .LATENCY(2)) dut0 (
    .CLK(clk), .RST_X(rst_n),
    .w_dram_addr(w_addr), .w_dram_wdata(w_wdata),
    .w_dram_we_t(w_we & ~sel), .w_dram_le(w_le & ~sel), .w_dram_ctrl(w_ctrl),
    .w_dram_odata(od0), .w_dram_busy(busy0), .w_dram_err(err0),
    .dbg_state_o(st0)
  );

  m_dram_resp #(.ADDR_WIDTH(12), .LATENCY(1)) dut1 (
    .CLK(clk), .RST_X(rst_n),
    .w_dram_addr(w_addr), .w_dram_wdata(w_wdata),
    .w_dram_we_t(w_we & sel), .w_dram_le(w_le & sel), .w_dram_ctrl(w_ctrl),
    .w_dram_odata(od1), .w_dram_busy(busy1), .w_dram_err(err1),
    .dbg_state_o(st1)
  );

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];              // {err, odata} per request
  logic [31:0] ref_mem [int];
  logic [31:0] last_od [2];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_bad(input logic [31:0] a, input logic [2:0] c);
    case (c)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return a[0];
      3'b010:         return a[1:0] != 2'b00;
      default:        return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [1:0] a,
                                           input logic [2:0] c);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (int'(a) * 8));
    h = 16'(w >> (int'(a[1]) * 16));
    case (c)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  function automatic int key_of(input bit s, input logic [31:0] a);
    return int'(s) * 4096 + int'(a[13:2]);
  endfunction

  // err must never stay high for two samples in a row
  logic err0_d = 1'b0, err1_d = 1'b0;
  always @(negedge clk) begin
    if (err0_d === 1'b1) check_eq("err0_width", {31'd0, err0}, 32'd0);
    if (err1_d === 1'b1) check_eq("err1_width", {31'd0, err1}, 32'd0);
    err0_d <= err0;
    err1_d <= err1;
  end

  // ---------------- driver ----------------
  // Called at a negedge; returns at the first negedge with busy low.
  // That makes consecutive calls back-to-back.
  // With hold=1, le stays high through the busy window.
  // The address and data also change then, so a second accept or a relatch would show up.
  task automatic do_req(input bit s, input bit we, input bit le, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [2:0] ctrl, input bit hold);
    bit          bad;
    int          k, cnt, lat;
    logic [31:0] w;
    logic [32:0] e;
    bad = is_bad(addr, ctrl);
    k   = key_of(s, addr);
    if (we) begin
      if (!bad) begin
        w = ref_mem.exists(k) ? ref_mem[k] : 32'hxxxxxxxx;
        case (ctrl[1:0])
          2'b00:   w[int'(addr[1:0]) * 8 +: 8]   = wd[7:0];
          2'b01:   w[int'(addr[1]) * 16 +: 16]   = wd[15:0];
          default: w = wd;
        endcase
        ref_mem[k] = w;
      end
    end else if (!bad) begin
      w = ref_mem.exists(k) ? ref_mem[k] : 32'hxxxxxxxx;
      last_od[s] = ld_model(w, addr[1:0], ctrl);
    end
    exp_q.push_back({bad, last_od[s]});

    sel = s; w_addr = addr; w_wdata = wd; w_ctrl = ctrl; w_we = we; w_le = le;
    @(negedge clk);
    w_we = 1'b0;
    w_le = hold;
    if (hold) begin
      w_addr  = addr ^ 32'h40;
      w_wdata = ~wd;
    end
    lat = s ? 1 : 2;
    cnt = 0;
    while ((s ? busy1 : busy0) === 1'b1 && cnt < 20) begin
      cnt++;
      if (hold && cnt >= lat) w_le = 1'b0;
      @(negedge clk);
    end
    check_eq("busy_cycles", 32'(cnt), 32'(lat));
    e = exp_q.pop_front();
    check_eq("odata", s ? od1 : od0, e[31:0]);
    check_eq("err", {31'd0, s ? err1 : err0}, {31'd0, e[32]});
    if (hold) begin
      @(negedge clk);
      check_eq("no_requeue", {31'd0, s ? busy1 : busy0}, 32'd0);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [2:0]  ctrl_tab [8];
    logic [31:0] a;
    bit          we, le;
    ctrl_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    sel = 1'b0; w_addr = '0; w_wdata = '0; w_we = 1'b0; w_le = 1'b0; w_ctrl = 3'b010;
    last_od[0] = 32'd0;
    last_od[1] = 32'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", {31'd0, busy0}, 32'd0);
    check_eq("rst_odata", od0, 32'd0);
    check_eq("rst_err", {31'd0, err0}, 32'd0);
    check_eq("rst_state", {31'd0, st0}, 32'd0);
    check_eq("rst_busy1", {31'd0, busy1}, 32'd0);
    check_eq("rst_odata1", od1, 32'd0);
    rst_n = 1'b1;

    // word store / load, then byte store and lane extraction
    do_req(0, 1, 0, 32'h8000_0010, 32'hDEAD_BEEF, 3'b010, 0);
    do_req(0, 0, 1, 32'h8000_0010, 32'h0,         3'b010, 0);
    do_req(0, 1, 0, 32'h8000_0013, 32'h0000_0080, 3'b000, 0);
    do_req(0, 0, 1, 32'h8000_0010, 32'h0,         3'b010, 0);
    do_req(0, 0, 1, 32'h8000_0013, 32'h0,         3'b000, 0);
    do_req(0, 0, 1, 32'h8000_0013, 32'h0,         3'b100, 0);
    do_req(0, 0, 1, 32'h8000_0012, 32'h0,         3'b001, 0);
    check_eq("lh_value", od0, 32'hFFFF_80AD);

    // misaligned / illegal requests
    do_req(0, 0, 1, 32'h8000_0012, 32'h0,         3'b010, 0);
    do_req(0, 1, 0, 32'h8000_0011, 32'h0000_5555, 3'b001, 0);
    do_req(0, 0, 1, 32'h8000_0010, 32'h0,         3'b010, 0);
    check_eq("word_after_bad_sh", od0, 32'h80AD_BEEF);
    do_req(0, 0, 1, 32'h8000_0010, 32'h0,         3'b011, 0);
    do_req(0, 1, 0, 32'h8000_0010, 32'h1111_1111, 3'b111, 0);

    // le held through ACCESS; le+we_t together is a store
    do_req(0, 0, 1, 32'h8000_0010, 32'h0,         3'b001, 1);
    do_req(0, 1, 1, 32'h8000_0014, 32'h0BAD_F00D, 3'b010, 0);
    do_req(0, 0, 1, 32'h8000_0014, 32'h0,         3'b010, 0);
    do_req(0, 0, 1, 32'h8000_0016, 32'h0,         3'b101, 0);

    // reset in the middle of a store aborts it; strobes during reset are ignored
    do_req(0, 1, 0, 32'h8000_0020, 32'hCAFE_F00D, 3'b010, 0);
    sel = 1'b0; w_addr = 32'h8000_0020; w_wdata = 32'h1234_5678; w_ctrl = 3'b010; w_we = 1'b1;
    @(negedge clk);
    w_we = 1'b0;
    check_eq("abort_busy_pre", {31'd0, busy0}, 32'd1);
    rst_n = 1'b0;
    w_le  = 1'b1;
    @(negedge clk);
    check_eq("abort_busy", {31'd0, busy0}, 32'd0);
    check_eq("abort_odata", od0, 32'd0);
    check_eq("abort_err", {31'd0, err0}, 32'd0);
    w_le  = 1'b0;
    rst_n = 1'b1;
    last_od[0] = 32'd0;
    last_od[1] = 32'd0;
    @(negedge clk);
    check_eq("rst_strobe_ignored", {31'd0, busy0}, 32'd0);
    do_req(0, 0, 1, 32'h8000_0020, 32'h0, 3'b010, 0);

    // random traffic over a pre-filled window, with address aliasing
    for (int i = 0; i < 8; i++)
      do_req(0, 1, 0, 32'h8000_0100 + 32'(4 * i), $urandom, 3'b010, 0);
    for (int i = 0; i < 40; i++) begin
      a  = 32'h8000_0100 + 32'($urandom_range(0, 31)) + (32'($urandom_range(0, 3)) << 14);
      we = 1'($urandom_range(0, 1));
      le = we ? 1'($urandom_range(0, 1)) : 1'b1;
      do_req(0, we, le, a, $urandom, ctrl_tab[$urandom_range(0, 7)], 0);
    end

    // LATENCY=1 instance: single busy cycle and address wrap
    do_req(1, 1, 0, 32'h8000_0010, 32'hA5A5_5A5A, 3'b010, 0);
    do_req(1, 0, 1, 32'h8000_0010, 32'h0,         3'b010, 0);
    do_req(1, 0, 1, 32'h8000_4010, 32'h0,         3'b010, 0);
    check_eq("wrap_value", od1, 32'hA5A5_5A5A);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/m_dram_resp.md
M_DRAM_RESP -- requirements
Module: m_dram_resp

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, meaning word-address bits (4096 words = 16 KiB).
REQ-002 SHALL have parameter LATENCY, default 2, meaning busy cycles per access; legal range 1..15.
REQ-003 SHALL have port CLK  in  1  sole clock, all state updates on posedge.
REQ-004 SHALL have port RST_X  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port w_dram_addr  in  32  byte address of request.
REQ-006 SHALL have port w_dram_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-007 SHALL have port w_dram_we_t  in  1  store request strobe.
REQ-008 SHALL have port w_dram_le  in  1  load request strobe.
REQ-009 SHALL have port w_dram_ctrl  in  3  funct3 size code: 000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal.
REQ-010 SHALL have port w_dram_odata  out  32  load result, registered.
REQ-011 SHALL have port w_dram_busy  out  1  access in progress, registered.
REQ-012 SHALL have port w_dram_err  out  1  one-cycle pulse, misaligned or illegal-ctrl access.

Function
REQ-013 SHALL implement FSM IDLE -> ACCESS -> IDLE; no other states.
REQ-014 SHALL accept a request in IDLE when w_dram_le or w_dram_we_t is 1 on a posedge, latching addr, wdata, ctrl, op.
REQ-015 SHALL assert w_dram_busy from the cycle after acceptance for exactly LATENCY cycles, then return to IDLE.
REQ-016 SHALL ignore all strobes while in ACCESS (no queuing, no latch update).
REQ-017 SHALL treat le and we_t both high at acceptance as a store (store priority).
REQ-018 SHALL index memory with addr[ADDR_WIDTH+1:2]; upper address bits ignored (aliasing wrap).
REQ-019 SHALL perform a store's memory write only on the final ACCESS cycle, byte-enabled: B writes lane addr[1:0], H writes lanes addr[1]*2..+1, W writes all lanes.
REQ-020 SHALL on load completion update w_dram_odata in the same edge busy falls: B/H sign-extended, BU/HU zero-extended, W unmodified, lane chosen by addr[1:0].
REQ-021 SHALL hold w_dram_odata unchanged across stores and until the next valid load completes.
REQ-022 SHALL classify misaligned as H/HU with addr[0]=1, or W with addr[1:0]!=00.
REQ-023 SHALL for misaligned or illegal-ctrl requests still run the full LATENCY busy window, perform no memory write, leave odata unchanged, and pulse w_dram_err for one cycle coincident with busy falling.
REQ-024 SHALL keep w_dram_err 0 in all other cycles.
REQ-025 SHALL allow a new request to be accepted on the first cycle busy is 0 (back-to-back throughput LATENCY+1 cycles/access).
REQ-026 SHALL not initialise memory contents; reads of unwritten words are X in simulation.

Reset
REQ-027 SHALL on RST_X=0 at a posedge force state IDLE, w_dram_busy=0, w_dram_odata=0, w_dram_err=0, counter=0.
REQ-028 SHALL abort any in-flight access on reset: no memory write performed, no err pulse.
REQ-029 SHALL leave memory contents untouched by reset.
REQ-030 SHALL ignore strobes in the cycle RST_X is 0.

Verification
REQ-031 SHALL cover: SW addr 0x80000010 data 0xDEADBEEF (LATENCY=2) -> busy high exactly 2 cycles; then LW 0x80000010 -> odata 0xDEADBEEF as busy falls.
REQ-032 SHALL cover: SB addr 0x80000013 data 0x00000080 after above -> LW gives 0x80ADBEEF; LB 0x80000013 -> 0xFFFFFF80; LBU -> 0x00000080; LH 0x80000012 -> 0xFFFF80AD.
REQ-033 SHALL cover: LW addr 0x80000012 -> busy 2 cycles, err pulse 1 cycle, odata keeps prior value; SH addr 0x80000011 -> err, word 0x80000010 unchanged.
REQ-034 SHALL cover: le strobe held during ACCESS and le+we_t together at acceptance -> single access only; combined request writes memory, odata unchanged.
REQ-035 SHALL cover: SW 0x80000020 data 0x12345678 with RST_X low on first busy cycle -> busy 0, odata 0 next cycle; later LW 0x80000020 returns pre-reset contents, not 0x12345678.
REQ-036 SHALL cover: LW 0x80000010 vs LW 0x80004010 (ADDR_WIDTH=12) -> identical data (wrap), with LATENCY=1 showing busy high 1 cycle.
